// File: rtl/draw_pkg.sv
// Shared definitions for the frame draw scheduler and its drawer clients:
// FSM state encoding, client slot numbers and screen geometry.
package draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SELECT     = 3'd1,
        S_START      = 3'd2,
        S_WAIT       = 3'd3,
        S_GAP        = 3'd4,
        S_FRAME_DONE = 3'd5
    } state_t;

    localparam int CLIENT_MAP     = 0;
    localparam int CLIENT_SPRITE0 = 1;
    localparam int CLIENT_SPRITE1 = 2;
    localparam int CLIENT_OVERLAY = 3;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // True while a client owns the buses (start pulse cycle plus waiting for done).
    function automatic logic in_bus_phase(input state_t s);
        return (s == S_START) || (s == S_WAIT);
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Scheduler <-> drawer signal bundle. The scheduler side uses the master
// modport; the top level / drawers (or a testbench) use the slave modport.
interface draw_scheduler_if #(
    parameter int NUM_CLIENTS = 4
);
    import draw_pkg::*;

    // Handshake: draw[i] is a one-cycle start pulse; client i owns the buses
    // while grant[i] is high and ends its turn with a one-cycle client_done[i]
    // pulse. Done pulses from clients that are not waiting on the bus are ignored.
    logic                   frame_tick;
    logic [NUM_CLIENTS-1:0] client_en;
    logic [NUM_CLIENTS-1:0] client_done;
    logic [NUM_CLIENTS-1:0] draw;
    logic [NUM_CLIENTS-1:0] grant;
    logic                   busy;
    logic                   frame_done;
    logic                   overrun;
    logic [NUM_CLIENTS-1:0] timeout_err;
    state_t                 state;

    modport master (
        input  frame_tick, client_en, client_done,
        output draw, grant, busy, frame_done, overrun, timeout_err, state
    );

    modport slave (
        output frame_tick, client_en, client_done,
        input  draw, grant, busy, frame_done, overrun, timeout_err, state
    );

endinterface

// File: rtl/draw_watchdog.sv
// Per-turn watchdog: counts bus-ownership cycles and flags the last allowed one.
module draw_watchdog #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer: on each accepted frame_tick, hands the shared pixel/ROM
// buses to each enabled drawer in index order, with a watchdog per turn.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic              clk,
    input  logic              resetn,
    draw_scheduler_if.master  bus
);

    localparam int IDX_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CLIENTS-1:0] en_q, en_d;
    logic [NUM_CLIENTS-1:0] to_err_q, to_err_d;
    logic                   ov_q, ov_d;

    logic [NUM_CLIENTS-1:0] sel_onehot;
    logic                   done_hit;
    logic                   wd_expired;

    assign sel_onehot = NUM_CLIENTS'(1) << idx_q;
    assign done_hit   = |(bus.client_done & sel_onehot);

    // Counter is held at zero outside a turn, so it reads 0 in the start cycle
    // and the grant lasts at most TIMEOUT_CYCLES cycles including that cycle.
    draw_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (!in_bus_phase(state_q)),
        .en      (in_bus_phase(state_q)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            en_q     <= '0;
            to_err_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            to_err_q <= to_err_d;
            ov_q     <= ov_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        en_d     = en_q;
        to_err_d = to_err_q;
        ov_d     = ov_q;

        if (bus.frame_tick && (state_q != S_IDLE)) begin
            ov_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.frame_tick) begin
                    en_d    = bus.client_en;
                    idx_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (|(en_q & sel_onehot)) begin
                    state_d = S_START;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FRAME_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving in the watchdog's last cycle still counts as done.
                if (done_hit) begin
                    state_d = S_GAP;
                end else if (wd_expired) begin
                    to_err_d = to_err_q | sel_onehot;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FRAME_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_FRAME_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant decodes straight from the state register, so an asynchronous reset
    // releases the buses without waiting for a clock edge.
    assign bus.draw        = (state_q == S_START) ? sel_onehot : '0;
    assign bus.grant       = in_bus_phase(state_q) ? sel_onehot : '0;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_done  = (state_q == S_FRAME_DONE);
    assign bus.overrun     = ov_q;
    assign bus.timeout_err = to_err_q;
    assign bus.state       = state_q;

endmodule
